// File: rtl/spi_regfile_param_if.sv
// SPI pin bundle between an SPI controller (master) and the register-file slave.
interface spi_regfile_param_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, ncs, copi, input cipo, cipo_oe);
  modport slave  (input sclk, ncs, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_regfile_param.sv
// SPI mode-0 slave register file: sclk/ncs/copi are oversampled in the clk domain,
// write frames commit on ncs rising, read frames shift the addressed register out on cipo.
module spi_regfile_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_param_if.slave         spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA2     = CNT_W'(ADDR_W + 2);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic [2:0] sclk_sync_q;
  logic [2:0] ncs_sync_q;
  logic [1:0] copi_sync_q;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]        frame_q, frame_d;
  logic [DATA_W-1:0]           tx_q, tx_d;
  logic                        rd_q, rd_d;
  logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
  logic [NUM_REGS-1:0]         wr_strobe_q, wr_strobe_d;
  logic                        frame_err_q, frame_err_d;
  logic                        cipo_q, cipo_d;
  logic                        cipo_oe_q, cipo_oe_d;

  logic                        sclk_rise_s;
  logic                        sclk_fall_s;
  logic                        ncs_rise_s;
  logic                        ncs_fall_s;
  logic                        copi_s;
  logic [FRAME_LEN-1:0]        frame_shift_s;
  logic [ADDR_W-1:0]           commit_addr_s;
  logic [DATA_W-1:0]           commit_data_s;

  // Register value at an address; out-of-range addresses read as zero.
  function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0]          addr,
                                               input logic [NUM_REGS*DATA_W-1:0] regs);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      val = (addr == ADDR_W'(i)) ? regs[i*DATA_W +: DATA_W] : val;
    end
    return val;
  endfunction

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= 3'b000;
      ncs_sync_q  <= 3'b111;
      copi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi.sclk};
      ncs_sync_q  <= {ncs_sync_q[1:0], spi.ncs};
      copi_sync_q <= {copi_sync_q[0], spi.copi};
    end
  end

  assign sclk_rise_s   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall_s   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ncs_rise_s    = ncs_sync_q[1] & ~ncs_sync_q[2];
  assign ncs_fall_s    = ~ncs_sync_q[1] & ncs_sync_q[2];
  assign copi_s        = copi_sync_q[1];
  assign frame_shift_s = {frame_q[FRAME_LEN-2:0], copi_s};
  assign commit_addr_s = frame_q[DATA_W +: ADDR_W];
  assign commit_data_s = frame_q[DATA_W-1:0];

  // Frame FSM, bit capture, read shifter and commit logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    tx_d        = tx_q;
    rd_d        = rd_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall_s) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          frame_d = '0;
          tx_d    = '0;
          rd_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (ncs_rise_s) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise_s) begin
          frame_d = (cnt_q < CNT_FULL) ? frame_shift_s : frame_q;
          cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
          // Read data is fetched as soon as the final address bit arrives.
          if ((cnt_q == CNT_LAST_ADDR) && !frame_shift_s[ADDR_W]) begin
            rd_d = 1'b1;
            tx_d = reg_at(frame_shift_s[ADDR_W-1:0], regs_q);
          end else begin
            rd_d = rd_q;
          end
        end else if (sclk_fall_s && rd_q && (cnt_q >= CNT_DATA2)) begin
          tx_d = tx_q << 1'd1;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_COMMIT: begin
        if (ncs_fall_s) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          frame_d = '0;
          tx_d    = '0;
          rd_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
          rd_d    = 1'b0;
          tx_d    = '0;
          if (cnt_q != CNT_FULL) begin
            frame_err_d = 1'b1;
          end else if (frame_q[FRAME_LEN-1]) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (commit_addr_s == ADDR_W'(i)) begin
                regs_d[i*DATA_W +: DATA_W] = commit_data_s;
                wr_strobe_d[i]             = 1'b1;
              end else begin
                regs_d[i*DATA_W +: DATA_W] = regs_q[i*DATA_W +: DATA_W];
                wr_strobe_d[i]             = 1'b0;
              end
            end
          end else begin
            frame_err_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cipo_d    = (state_d == ST_ACTIVE) & rd_d & tx_d[DATA_W-1];
    cipo_oe_d = ~ncs_sync_q[1];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
    end
  end

  assign regs_flat   = regs_q;
  assign wr_strobe   = wr_strobe_q;
  assign frame_err   = frame_err_q;
  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = cipo_oe_q;

endmodule
